// File: rtl/branch_compare_unit.sv
// Branch / set-less-than resolution unit. Borrows the core's combinational ALU
// for a SUB (condition flags) and, for branches, an ADD (PC+imm target).
module branch_compare_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [WIDTH-1:0] req_pc,
  input  logic [WIDTH-1:0] req_imm,
  output logic [3:0]       alu_g_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_g,
  input  logic [3:0]       alu_flags,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_taken,
  output logic [WIDTH-1:0] resp_result,
  output logic [WIDTH-1:0] resp_target,
  output logic             resp_illegal
);

  localparam logic [3:0] G_ADD = 4'b0000;
  localparam logic [3:0] G_SUB = 4'b0001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_TGT,
    S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic             taken_q, taken_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             illegal_q, illegal_d;

  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, pc_q, imm_q;
  logic             accept;

  logic flag_z, flag_c, flag_n, flag_v;
  logic eq, lt, ltu;

  // funct3 010/011 are holes in the branch space but are exactly SLT/SLTU
  // when op[3] is set, so legality flips on the same two bits.
  function automatic logic op_legal(input logic [3:0] op);
    logic hole;
    hole = (op[2:1] == 2'b01);
    return op[3] ? hole : !hole;
  endfunction

  function automatic logic branch_cond(input logic [2:0] f3, input logic c_eq,
                                       input logic c_lt, input logic c_ltu);
    logic c;
    case (f3)
      3'b000:  c = c_eq;
      3'b001:  c = !c_eq;
      3'b100:  c = c_lt;
      3'b101:  c = !c_lt;
      3'b110:  c = c_ltu;
      3'b111:  c = !c_ltu;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

  assign {flag_z, flag_c, flag_n, flag_v} = alu_flags;

  // C is the carry of a + ~b + 1, so C=1 means no borrow.
  assign eq  = flag_z;
  assign ltu = !flag_c;
  assign lt  = flag_n ^ flag_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      taken_q   <= 1'b0;
      result_q  <= '0;
      target_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      taken_q   <= taken_d;
      result_q  <= result_d;
      target_q  <= target_d;
      illegal_q <= illegal_d;
    end
  end

  // Operand latches carry no reset; they are only read in CMP/TGT.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q  <= req_op;
      a_q   <= req_a;
      b_q   <= req_b;
      pc_q  <= req_pc;
      imm_q <= req_imm;
    end
  end

  always_comb begin
    state_d   = state_q;
    taken_d   = taken_q;
    result_d  = result_q;
    target_d  = target_q;
    illegal_d = illegal_q;
    accept    = 1'b0;
    alu_g_sel = G_ADD;
    alu_a     = '0;
    alu_b     = '0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          taken_d   = 1'b0;
          result_d  = '0;
          target_d  = '0;
          illegal_d = !op_legal(req_op);
          state_d   = op_legal(req_op) ? S_CMP : S_RESP;
        end
      end
      S_CMP: begin
        alu_g_sel = G_SUB;
        alu_a     = a_q;
        alu_b     = b_q;
        if (op_q[3]) begin
          result_d = {{(WIDTH-1){1'b0}}, (op_q[0] ? ltu : lt)};
          taken_d  = 1'b0;
          state_d  = S_RESP;
        end else begin
          taken_d  = branch_cond(op_q[2:0], eq, lt, ltu);
          state_d  = S_TGT;
        end
      end
      S_TGT: begin
        alu_g_sel = G_ADD;
        alu_a     = pc_q;
        alu_b     = imm_q;
        target_d  = alu_g;
        state_d   = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready    = (state_q == S_IDLE) && !rst;
  assign resp_valid   = (state_q == S_RESP);
  assign resp_taken   = taken_q;
  assign resp_result  = result_q;
  assign resp_target  = target_q;
  assign resp_illegal = illegal_q;

endmodule

// File: tb/tb_branch_compare_unit.sv
// Directed bench for branch_compare_unit with a behavioural combinational ALU
// standing in for the core's ALU port.
module tb_branch_compare_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a, req_b, req_pc, req_imm;
  logic [3:0]  alu_g_sel;
  logic [31:0] alu_a, alu_b, alu_g;
  logic [3:0]  alu_flags;
  logic        resp_valid, resp_ready, resp_taken, resp_illegal;
  logic [31:0] resp_result, resp_target;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_compare_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_pc(req_pc), .req_imm(req_imm),
    .alu_g_sel(alu_g_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_g(alu_g), .alu_flags(alu_flags),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_taken(resp_taken), .resp_result(resp_result),
    .resp_target(resp_target), .resp_illegal(resp_illegal)
  );

  // Core ALU: 0000 ADD, 0001 SUB (a + ~b + 1), flags {Z,C,N,V}.
  logic [32:0] alu_sum;
  logic        alu_v;
  always_comb begin
    alu_sum = 33'd0;
    alu_v   = 1'b0;
    if (alu_g_sel == 4'b0001) begin
      alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
      alu_v   = (alu_a[31] != alu_b[31]) && (alu_sum[31] != alu_a[31]);
    end else begin
      alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
      alu_v   = (alu_a[31] == alu_b[31]) && (alu_sum[31] != alu_a[31]);
    end
  end
  assign alu_g     = alu_sum[31:0];
  assign alu_flags = {(alu_sum[31:0] == 32'd0), alu_sum[32], alu_sum[31], alu_v};

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, pc, imm;
    int          lat;
    logic        taken;
    logic [31:0] result, target;
    logic        illegal;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Presents a request one cycle and returns #1 after the accept edge.
  task automatic issue(input vec_t v, input string nm);
    req_op    = v.op;
    req_a     = v.a;
    req_b     = v.b;
    req_pc    = v.pc;
    req_imm   = v.imm;
    req_valid = 1'b1;
    chk({nm, " req_ready"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic await_resp(input vec_t v, input string nm);
    int lat;
    lat = 1;
    while (lat <= 8) begin
      if (resp_valid) break;
      if (lat == 1) begin
        chk({nm, " cmp_sel"}, {28'd0, alu_g_sel}, 32'h1);
        chk({nm, " cmp_a"}, alu_a, v.a);
        chk({nm, " cmp_b"}, alu_b, v.b);
      end
      if (lat == 2) begin
        chk({nm, " tgt_sel"}, {28'd0, alu_g_sel}, 32'h0);
        chk({nm, " tgt_a"}, alu_a, v.pc);
        chk({nm, " tgt_b"}, alu_b, v.imm);
      end
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, lat, v.lat);
    chk({nm, " taken"}, {31'd0, resp_taken}, {31'd0, v.taken});
    chk({nm, " result"}, resp_result, v.result);
    chk({nm, " target"}, resp_target, v.target);
    chk({nm, " illegal"}, {31'd0, resp_illegal}, {31'd0, v.illegal});
    chk({nm, " resp_alu_a"}, alu_a, 32'd0);
    chk({nm, " req_ready_busy"}, {31'd0, req_ready}, 32'd0);
  endtask

  task automatic handshake(input string nm);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({nm, " post_hs_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({nm, " post_hs_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    issue(v, nm);
    await_resp(v, nm);
    handshake(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //        op       a             b             pc            imm           lat tk result  target        ill
    vecs[0]  = '{4'b0000, 32'h12345678, 32'h12345678, 32'h00000100, 32'hFFFFFFF0, 3, 1, 32'd0, 32'h000000F0, 0}; // BEQ
    vecs[1]  = '{4'b0100, 32'h7FFFFFFF, 32'h80000000, 32'h00002000, 32'h00000010, 3, 0, 32'd0, 32'h00002010, 0}; // BLT ovf
    vecs[2]  = '{4'b0101, 32'h7FFFFFFF, 32'h80000000, 32'h00002000, 32'h00000010, 3, 1, 32'd0, 32'h00002010, 0}; // BGE ovf
    vecs[3]  = '{4'b1011, 32'h00000001, 32'hFFFFFFFF, 32'h00000500, 32'h00000004, 2, 0, 32'd1, 32'h00000000, 0}; // SLTU
    vecs[4]  = '{4'b1010, 32'h00000001, 32'hFFFFFFFF, 32'h00000500, 32'h00000004, 2, 0, 32'd0, 32'h00000000, 0}; // SLT
    vecs[5]  = '{4'b0010, 32'h00000001, 32'h00000002, 32'h00000600, 32'h00000008, 1, 0, 32'd0, 32'h00000000, 1}; // illegal
    vecs[6]  = '{4'b1000, 32'h00000001, 32'h00000002, 32'h00000600, 32'h00000008, 1, 0, 32'd0, 32'h00000000, 1}; // illegal
    vecs[7]  = '{4'b0011, 32'h00000009, 32'h00000009, 32'h00000600, 32'h00000008, 1, 0, 32'd0, 32'h00000000, 1}; // illegal
    vecs[8]  = '{4'b0110, 32'h00000005, 32'h00000007, 32'h00000040, 32'h00000008, 3, 1, 32'd0, 32'h00000048, 0}; // BLTU
    vecs[9]  = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFC, 32'h00000008, 3, 1, 32'd0, 32'h00000004, 0}; // BGEU wrap
    vecs[10] = '{4'b0001, 32'h00000003, 32'h00000003, 32'h00000000, 32'h00000000, 3, 0, 32'd0, 32'h00000000, 0}; // BNE
    vecs[11] = '{4'b1010, 32'h80000000, 32'h00000000, 32'h00000000, 32'h00000000, 2, 0, 32'd1, 32'h00000000, 0}; // SLT min
    vecs[12] = '{4'b0100, 32'hFFFFFFFF, 32'h00000001, 32'h00001000, 32'hFFFFF000, 3, 1, 32'd0, 32'h00000000, 0}; // BLT neg

    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0; req_pc = '0; req_imm = '0;
    #1;
    chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst taken", {31'd0, resp_taken}, 32'd0);
    chk("rst result", resp_result, 32'd0);
    chk("rst target", resp_target, 32'd0);
    chk("rst illegal", {31'd0, resp_illegal}, 32'd0);
    chk("rst alu_sel", {28'd0, alu_g_sel}, 32'd0);
    chk("rst alu_a", alu_a, 32'd0);
    chk("rst alu_b", alu_b, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("idle req_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // BNE under backpressure; a competing request is offered while busy.
    v = '{4'b0001, 32'h00000001, 32'h00000002, 32'h00000300, 32'h00000020, 3, 1, 32'd0, 32'h00000320, 0};
    issue(v, "bp");
    req_valid = 1'b1; req_op = 4'b1011; req_a = 32'hDEAD0000; req_pc = 32'hBEEF0000;
    await_resp(v, "bp");
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp hold valid", {31'd0, resp_valid}, 32'd1);
      chk("bp hold taken", {31'd0, resp_taken}, 32'd1);
      chk("bp hold target", resp_target, 32'h00000320);
      chk("bp hold result", resp_result, 32'd0);
      chk("bp hold illegal", {31'd0, resp_illegal}, 32'd0);
      chk("bp hold req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    handshake("bp");

    // Reset while in TGT aborts without a response.
    v = '{4'b0000, 32'h00000004, 32'h00000004, 32'h00000800, 32'h00000010, 3, 1, 32'd0, 32'h00000810, 0};
    issue(v, "abort");
    @(posedge clk); #1;
    chk("abort tgt_sel", {28'd0, alu_g_sel}, 32'd0);
    chk("abort tgt_a", alu_a, 32'h00000800);
    #2 rst = 1'b1;
    #1;
    chk("abort resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("abort alu_a", alu_a, 32'd0);
    chk("abort alu_b", alu_b, 32'd0);
    chk("abort alu_sel", {28'd0, alu_g_sel}, 32'd0);
    chk("abort req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("abort no_resp", {31'd0, resp_valid}, 32'd0);
      chk("abort ready", {31'd0, req_ready}, 32'd1);
    end
    v = '{4'b0111, 32'h00000005, 32'h00000005, 32'h00000010, 32'h00000010, 3, 1, 32'd0, 32'h00000020, 0};
    run_vec(v, "bgeu_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
